// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   N-client arbiter in front of the single-master SDRAM bus. One client is
//   granted at a time. Its address, data and op are latched and one
//   transaction runs downstream. The completion and read data go back to
//   that client only.
//   Flow: IDLE -> BUSY (downstream request held) -> RELEASE (1-cycle
//   completion pulse) -> IDLE.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_read/i_req_write   per-client level requests
//   i_req_addr               packed addresses, client k at [k*ADDR_W +: ADDR_W]
//   i_req_writedata          packed write data, same packing
//   o_client_finished        one-hot 1-cycle completion pulse
//   o_client_error           pulse with finished when the watchdog aborted
//   o_client_readdata        read data, valid with o_client_finished
//   o_grant_id               current / last granted client
//   o_busy                   high in BUSY and RELEASE
//   o_conflict               sticky read+write-together flag
//   sdram_*                  downstream single-master bus
module sdram_arbiter #(
    parameter int NUM_CLIENTS    = 5,
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_CLIENTS-1:0]            i_req_read,
    input  logic [NUM_CLIENTS-1:0]            i_req_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]     i_req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0]     i_req_writedata,
    output logic [NUM_CLIENTS-1:0]            o_client_finished,
    output logic [NUM_CLIENTS-1:0]            o_client_error,
    output logic [DATA_W-1:0]                 o_client_readdata,
    output logic [$clog2(NUM_CLIENTS)-1:0]    o_grant_id,
    output logic                              o_busy,
    output logic                              o_conflict,
    output logic                              sdram_read,
    output logic                              sdram_write,
    output logic [ADDR_W-1:0]                 sdram_addr,
    output logic [DATA_W-1:0]                 sdram_writedata,
    input  logic [DATA_W-1:0]                 sdram_readdata,
    input  logic                              sdram_finished
);

    localparam int GW = $clog2(NUM_CLIENTS);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]             state;
    logic [GW-1:0]          last;
    logic [WW-1:0]          wdog;
    logic [NUM_CLIENTS-1:0] req_act;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [GW-1:0]          win_id;
    logic                   win_found;
    logic                   wd_expire;
    int                     idx;

    assign req_act   = i_req_read | i_req_write;
    assign win_found = |req_act;
    assign o_busy    = (state != ST_IDLE);
    assign grant_oh  = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << o_grant_id;
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wdog == WW'(TIMEOUT_CYCLES - 1));

    // Winner select. Both loops run from far to near, so the last hit
    // (nearest candidate) overrides the earlier ones.
    always_comb begin
        win_id = '0;
        idx    = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--)
                if (req_act[i]) win_id = GW'(i);
        end else begin
            // cyclic search starting at last+1, ending at last itself
            for (int i = NUM_CLIENTS; i >= 1; i--) begin
                idx = (int'(last) + i) % NUM_CLIENTS;
                if (req_act[idx]) win_id = GW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= ST_IDLE;
            last              <= GW'(NUM_CLIENTS - 1);
            wdog              <= '0;
            o_client_finished <= '0;
            o_client_error    <= '0;
            o_client_readdata <= '0;
            o_grant_id        <= '0;
            o_conflict        <= 1'b0;
            sdram_read        <= 1'b0;
            sdram_write       <= 1'b0;
            sdram_addr        <= '0;
            sdram_writedata   <= '0;
        end else begin
            // completion outputs are single-cycle pulses
            o_client_finished <= '0;
            o_client_error    <= '0;
            o_client_readdata <= '0;
            if (|(i_req_read & i_req_write))
                o_conflict <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        o_grant_id      <= win_id;
                        sdram_addr      <= i_req_addr[win_id*ADDR_W +: ADDR_W];
                        sdram_writedata <= i_req_writedata[win_id*DATA_W +: DATA_W];
                        // read+write together resolves to a write
                        sdram_write     <= i_req_write[win_id];
                        sdram_read      <= ~i_req_write[win_id];
                        wdog            <= '0;
                        state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (sdram_finished || wd_expire) begin
                        sdram_read        <= 1'b0;
                        sdram_write       <= 1'b0;
                        sdram_addr        <= '0;
                        sdram_writedata   <= '0;
                        o_client_finished <= grant_oh;
                        // a real completion in the expiry cycle wins over the abort
                        o_client_error    <= sdram_finished ? '0 : grant_oh;
                        o_client_readdata <= sdram_finished ? sdram_readdata : '0;
                        state             <= ST_RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (ARB_MODE != 0)
                        last <= o_grant_id;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: a round-robin instance (TIMEOUT_CYCLES=16) and a
// fixed-priority instance share clock and reset but have separate stimulus.
module tb_sdram_arbiter;

    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance
    logic [N-1:0]    rd, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wd;
    logic [DW-1:0]   rdat;
    logic            fin;
    logic [N-1:0]    cfin, cerr;
    logic [DW-1:0]   crd;
    logic [2:0]      gid;
    logic            busy, conf, s_rd, s_wr;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wd;

    // fixed-priority instance
    logic [N-1:0]    f_rd, f_wr;
    logic [N*AW-1:0] f_addr;
    logic [N*DW-1:0] f_wd;
    logic [DW-1:0]   f_rdat;
    logic            f_fin;
    logic [N-1:0]    f_cfin, f_cerr;
    logic [DW-1:0]   f_crd;
    logic [2:0]      f_gid;
    logic            f_busy, f_conf, f_s_rd, f_s_wr;
    logic [AW-1:0]   f_s_addr;
    logic [DW-1:0]   f_s_wd;

    sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(16)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req_read(rd), .i_req_write(wr),
        .i_req_addr(addr), .i_req_writedata(wd),
        .o_client_finished(cfin), .o_client_error(cerr), .o_client_readdata(crd),
        .o_grant_id(gid), .o_busy(busy), .o_conflict(conf),
        .sdram_read(s_rd), .sdram_write(s_wr), .sdram_addr(s_addr),
        .sdram_writedata(s_wd), .sdram_readdata(rdat), .sdram_finished(fin));

    sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(1024)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_req_read(f_rd), .i_req_write(f_wr),
        .i_req_addr(f_addr), .i_req_writedata(f_wd),
        .o_client_finished(f_cfin), .o_client_error(f_cerr), .o_client_readdata(f_crd),
        .o_grant_id(f_gid), .o_busy(f_busy), .o_conflict(f_conf),
        .sdram_read(f_s_rd), .sdram_write(f_s_wr), .sdram_addr(f_s_addr),
        .sdram_writedata(f_s_wd), .sdram_readdata(f_rdat), .sdram_finished(f_fin));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge, sample/drive 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int ord[6] = '{0, 1, 4, 0, 1, 4};

    initial begin
        rd = '0; wr = '0; addr = '0; wd = '0; rdat = '0; fin = 1'b0;
        f_rd = '0; f_wr = '0; f_addr = '0; f_wd = '0; f_rdat = '0; f_fin = 1'b0;
        #1;
        do_reset();

        // ---- reset state ----
        chk("rst_fin",  cfin, 0);
        chk("rst_err",  cerr, 0);
        chk("rst_rd",   crd, 0);
        chk("rst_gid",  gid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conf", conf, 0);
        chk("rst_srd",  s_rd, 0);
        chk("rst_swr",  s_wr, 0);
        chk("rst_addr", s_addr, 0);

        // ---- single read, client 2 ----
        rd[2] = 1'b1;
        addr[2*AW +: AW] = 23'h000123;
        tick();
        chk("sr_srd",  s_rd, 1);
        chk("sr_swr",  s_wr, 0);
        chk("sr_addr", s_addr, 23'h000123);
        chk("sr_gid",  gid, 2);
        chk("sr_busy", busy, 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("sr_nofin", cfin, 0);
        end
        // cycle 5: bus completes, 4 cycles after sdram_read rose
        fin = 1'b1; rdat = 32'hDEADBEEF;
        tick();
        fin = 1'b0; rdat = 32'h0;
        chk("sr_fin",    cfin, 5'b00100);
        chk("sr_data",   crd, 32'hDEADBEEF);
        chk("sr_err",    cerr, 0);
        chk("sr_srd_lo", s_rd, 0);
        rd[2] = 1'b0;
        tick();
        chk("sr_fin_lo", cfin, 0);
        chk("sr_idle",   busy, 0);

        // ---- fixed priority: 3 and 1 together ----
        f_rd[3] = 1'b1; f_rd[1] = 1'b1;
        tick();
        chk("fp_g1", f_gid, 1);
        f_fin = 1'b1;
        tick();
        f_fin = 1'b0;
        chk("fp_f1", f_cfin, 5'b00010);
        f_rd[1] = 1'b0;
        tick();
        tick();
        chk("fp_g3", f_gid, 3);
        // client 0 arrives while 3 is busy
        f_rd[0] = 1'b1;
        tick();
        tick();
        chk("fp_g3_hold", f_gid, 3);
        chk("fp_busy",    f_s_rd, 1);
        f_fin = 1'b1;
        tick();
        f_fin = 1'b0;
        chk("fp_f3", f_cfin, 5'b01000);
        f_rd[3] = 1'b0;
        tick();
        tick();
        chk("fp_g0", f_gid, 0);
        f_fin = 1'b1;
        tick();
        f_fin = 1'b0;
        chk("fp_f0", f_cfin, 5'b00001);
        f_rd[0] = 1'b0;
        tick();

        // ---- round robin: clients 0, 1, 4 write continuously ----
        do_reset();
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW] = AW'(k * 16);
            wd[k*DW +: DW]   = 32'h10000000 + DW'(k);
        end
        wr[0] = 1'b1; wr[1] = 1'b1; wr[4] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("rr_gid",  gid, ord[t]);
            chk("rr_swr",  s_wr, 1);
            chk("rr_wd",   s_wd, 32'h10000000 + ord[t]);
            chk("rr_addr", s_addr, ord[t] * 16);
            fin = 1'b1;
            tick();
            fin = 1'b0;
            chk("rr_fin", cfin, 5'b00001 << ord[t]);
            tick();
            chk("rr_idle", busy, 0);
        end
        wr = '0;
        chk("rr_noconf", conf, 0);

        // ---- conflict: client 1 read+write ----
        rd[1] = 1'b1; wr[1] = 1'b1;
        wd[1*DW +: DW] = 32'hA5A5A5A5;
        tick();
        chk("cf_swr",  s_wr, 1);
        chk("cf_srd",  s_rd, 0);
        chk("cf_wd",   s_wd, 32'hA5A5A5A5);
        chk("cf_conf", conf, 1);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        rd[1] = 1'b0; wr[1] = 1'b0;
        chk("cf_fin", cfin, 5'b00010);
        tick();
        tick();
        chk("cf_sticky", conf, 1);

        // ---- watchdog: client 3 read, bus never finishes ----
        rd[3] = 1'b1;
        rdat  = 32'hFFFFFFFF;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("wd_nofin", cfin, 0);
        end
        chk("wd_still_rd", s_rd, 1);
        tick();
        chk("wd_fin",  cfin, 5'b01000);
        chk("wd_err",  cerr, 5'b01000);
        chk("wd_data", crd, 0);
        rd[3] = 1'b0;
        tick();
        chk("wd_err_lo", cerr, 0);
        // next request served normally
        rd[0] = 1'b1;
        tick();
        chk("wd_next_g", gid, 0);
        fin = 1'b1; rdat = 32'h11223344;
        tick();
        fin = 1'b0; rdat = 32'h0;
        chk("wd_next_fin",  cfin, 5'b00001);
        chk("wd_next_err",  cerr, 0);
        chk("wd_next_data", crd, 32'h11223344);
        rd[0] = 1'b0;
        tick();

        // ---- reset while client 4 is busy ----
        wr[4] = 1'b1;
        tick();
        chk("rb_gid", gid, 4);
        chk("rb_swr", s_wr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_swr0", s_wr, 0);
        chk("rb_gid0", gid, 0);
        chk("rb_busy", busy, 0);
        chk("rb_fin",  cfin, 0);
        chk("rb_conf", conf, 0);
        rd[0] = 1'b1;
        tick();
        chk("rb_first", gid, 0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("rb_fin0", cfin, 5'b00001);
        rd = '0; wr = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
